phy_sync_ctrl: RTL and testbench

Receive-side lane synchronization controller for the PHY. Sits after the serial-to-parallel converter on the `clk_2f` domain, hunts for the COM alignment symbol, and declares the lane active after a run of consecutive COMs. While active it forwards data bytes and strips COMs. It drops back to search when the incoming stream goes idle for too long.

---
 rtl/phy_sync_ctrl.sv | 143 ++++++++++++++
 tb/tb_phy_sync_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/phy_sync_ctrl.sv
// Receive lane sync controller: hunts for COM, locks after LOCK_COUNT COMs, forwards non-COM bytes while active.
// Optional loss-of-sync counter port err_count enabled by defining PHY_SYNC_ERRCNT_EN.
module phy_sync_ctrl #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned COUNT_W    = 3
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic [1:0] state
`ifdef PHY_SYNC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] LOCK_C = COUNT_W'(LOCK_COUNT);
    localparam logic [COUNT_W-1:0] LOSS_C = COUNT_W'(LOSS_COUNT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COUNT_W-1:0] r_com_cnt;
    logic [COUNT_W-1:0] r_gap_cnt;
    logic [COUNT_W-1:0] w_com_nxt;
    logic [COUNT_W-1:0] w_gap_nxt;
    logic [COUNT_W-1:0] w_com_inc;
    logic [COUNT_W-1:0] w_gap_inc;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_active;
    logic               w_is_com;

    assign w_com_inc = r_com_cnt + 1'b1;
    assign w_gap_inc = r_gap_cnt + 1'b1;
    assign w_is_com  = valid_in && (data_in == COM);

    always_comb begin
        w_state_nxt = r_state;
        w_com_nxt   = r_com_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_is_com) begin
                    w_state_nxt = LOCKING;
                    w_com_nxt   = COUNT_W'(1);
                end
            end
            LOCKING: begin
                if (valid_in) begin
                    if (w_is_com) begin
                        if (w_com_inc == LOCK_C) begin
                            w_state_nxt = ACTIVE;
                            w_com_nxt   = '0;
                            w_gap_nxt   = '0;
                        end else begin
                            w_com_nxt = w_com_inc;
                        end
                    end else begin
                        w_state_nxt = SEARCH;
                        w_com_nxt   = '0;
                    end
                end
            end
            ACTIVE: begin
                if (valid_in) begin
                    w_gap_nxt = '0;
                    if (!w_is_com) begin
                        w_data_nxt  = data_in;
                        w_valid_nxt = 1'b1;
                    end
                end else if (w_gap_inc == LOSS_C) begin
                    w_state_nxt = SEARCH;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = w_gap_inc;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
                w_com_nxt   = '0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // active is registered from the next-state decode so it changes on the same edge as state
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_com_cnt <= '0;
            r_gap_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_com_cnt <= w_com_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_active  <= (w_state_nxt == ACTIVE);
        end
    end

`ifdef PHY_SYNC_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic       w_loss;

    assign w_loss = (r_state == ACTIVE) && !valid_in && (w_gap_inc == LOSS_C);

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            r_err_cnt <= '0;
        end else if (w_loss && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign active    = r_active;
    assign state     = r_state;

endmodule

// File: tb/tb_phy_sync_ctrl.sv
// Directed bench for phy_sync_ctrl: expected outputs queued per driven cycle, checked 1 time unit after the edge.
// Also checks err_count when PHY_SYNC_ERRCNT_EN is defined.
module tb_phy_sync_ctrl;

    logic       clk_2f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [1:0] state;
`ifdef PHY_SYNC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    phy_sync_ctrl #(
        .COM        (8'hBC),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3),
        .COUNT_W    (3)
    ) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .state     (state)
`ifdef PHY_SYNC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       act;
        logic       vo;
        logic [7:0] dout;
        logic [7:0] err;
    } exp_t;

    exp_t queue_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] m_err = 8'h00;

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check_out();
        exp_t e;
        if (queue_exp.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = queue_exp.pop_front();
        n_tests++;
        assert (state === e.st) else begin
            n_fail++;
            $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
        end
        n_tests++;
        assert (active === e.act) else begin
            n_fail++;
            $error("FAIL %s.active observed=%0b expected=%0b", e.tag, active, e.act);
        end
        n_tests++;
        assert (valid_out === e.vo) else begin
            n_fail++;
            $error("FAIL %s.valid_out observed=%0b expected=%0b", e.tag, valid_out, e.vo);
        end
        n_tests++;
        assert (data_out === e.dout) else begin
            n_fail++;
            $error("FAIL %s.data_out observed=%02h expected=%02h", e.tag, data_out, e.dout);
        end
`ifdef PHY_SYNC_ERRCNT_EN
        n_tests++;
        assert (err_count === e.err) else begin
            n_fail++;
            $error("FAIL %s.err_count observed=%0d expected=%0d", e.tag, err_count, e.err);
        end
`endif
    endtask

    // Drive one cycle at the falling edge, queue the expectation, check after the rising edge.
    task automatic step(input string tag, input logic rst_n, input logic v, input logic [7:0] d,
                        input logic [1:0] es, input logic evo, input logic [7:0] edout);
        exp_t e;
        @(negedge clk_2f);
        reset    = rst_n;
        valid_in = v;
        data_in  = d;
        e.tag  = tag;
        e.st   = es;
        e.act  = (es == 2'd2);
        e.vo   = evo;
        e.dout = edout;
        e.err  = m_err;
        queue_exp.push_back(e);
        @(posedge clk_2f);
        #1;
        check_out();
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset with valid COMs present
        step("rst0", 1'b0, 1'b1, 8'hBC, 2'd0, 1'b0, 8'h00);
        step("rst1", 1'b0, 1'b1, 8'hBC, 2'd0, 1'b0, 8'h00);
        step("srch_nc", 1'b1, 1'b1, 8'h55, 2'd0, 1'b0, 8'h00);

        // Lock with a gap in the COM run
        step("lk_c1",  1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h00);
        step("lk_c2",  1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h00);
        step("lk_gap", 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 8'h00);
        step("lk_c3",  1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h00);
        step("lk_c4",  1'b1, 1'b1, 8'hBC, 2'd2, 1'b0, 8'h00);
        step("fw_11",  1'b1, 1'b1, 8'h11, 2'd2, 1'b1, 8'h11);
        step("fw_22",  1'b1, 1'b1, 8'h22, 2'd2, 1'b1, 8'h22);

        // COM stripping
        step("st_a1", 1'b1, 1'b1, 8'hA1, 2'd2, 1'b1, 8'hA1);
        step("st_bc", 1'b1, 1'b1, 8'hBC, 2'd2, 1'b0, 8'hA1);
        step("st_a2", 1'b1, 1'b1, 8'hA2, 2'd2, 1'b1, 8'hA2);

        // Loss boundary: two idles survive, third consecutive idle drops lock
        step("ls_i1", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 8'hA2);
        step("ls_i2", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 8'hA2);
        step("ls_33", 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 8'h33);
        step("ls_j1", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 8'h33);
        step("ls_j2", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 8'h33);
        m_err = 8'h01;
        step("ls_j3", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h33);

        // Broken lock, then relock
        step("bk_c1", 1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h33);
        step("bk_c2", 1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h33);
        step("bk_55", 1'b1, 1'b1, 8'h55, 2'd0, 1'b0, 8'h33);
        step("bk_d1", 1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h33);
        step("bk_d2", 1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h33);
        step("bk_d3", 1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h33);
        step("bk_d4", 1'b1, 1'b1, 8'hBC, 2'd2, 1'b0, 8'h33);
        step("bk_44", 1'b1, 1'b1, 8'h44, 2'd2, 1'b1, 8'h44);

        // Reset while forwarding, then relock needs four new COMs
        m_err = 8'h00;
        step("rm_rst", 1'b0, 1'b1, 8'h66, 2'd0, 1'b0, 8'h00);
        step("rm_c1",  1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h00);
        step("rm_c2",  1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h00);
        step("rm_c3",  1'b1, 1'b1, 8'hBC, 2'd1, 1'b0, 8'h00);
        step("rm_c4",  1'b1, 1'b1, 8'hBC, 2'd2, 1'b0, 8'h00);
        step("rm_77",  1'b1, 1'b1, 8'h77, 2'd2, 1'b1, 8'h77);
        step("rm_idl", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 8'h77);

        n_tests++;
        assert (queue_exp.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", queue_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
